// File: rtl/popcount_bist_checker_if.sv
// Signal bundle between the BIST checker (master) and the two ones-counters plus status consumers (slave).
// Handshake: start is a level sampled on the rising edge only in IDLE or DONE; the counters are free-running combinational results of vec.
interface popcount_bist_checker_if;
  logic       start;
  logic [2:0] vec;
  logic [1:0] dut_a;
  logic [1:0] dut_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic       err_a;
  logic       err_b;
  logic [2:0] first_err_vec;
  logic       first_err_valid;
  logic [1:0] fsm_state;

  modport master (
    input  start, dut_a, dut_b,
    output vec, busy, done, pass, err_count, err_a, err_b,
           first_err_vec, first_err_valid, fsm_state
  );

  modport slave (
    output start, dut_a, dut_b,
    input  vec, busy, done, pass, err_count, err_a, err_b,
           first_err_vec, first_err_valid, fsm_state
  );
endinterface

// File: rtl/popcount_bist_checker.sv
// Exhaustive self-test for two 3-input ones-counters: steps vec 0..7, holds each for DWELL cycles,
// compares both results against a golden popcount in the last cycle of each window and logs mismatches.
module popcount_bist_checker #(
  parameter int unsigned DWELL = 4
) (
  input logic                    clk,
  input logic                    rst,
  popcount_bist_checker_if.master bus
);
  localparam logic [7:0] LAST = 8'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] timer;
  logic [2:0] vec;
  logic [3:0] err_count;
  logic       err_a;
  logic       err_b;
  logic [2:0] first_err_vec;
  logic       first_err_valid;
  logic       launch;
  logic       sample;
  logic [1:0] exp_cnt;
  logic       mis_a;
  logic       mis_b;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    launch     = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          launch     = 1'b1;
          next_state = APPLY;
        end
      end
      APPLY: begin
        if (timer == LAST) begin
          sample = 1'b1;
          if (vec == 3'd7) next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign exp_cnt = {1'b0, vec[2]} + {1'b0, vec[1]} + {1'b0, vec[0]};
  assign mis_a   = sample && (bus.dut_a != exp_cnt);
  assign mis_b   = sample && (bus.dut_b != exp_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      vec             <= 3'd0;
      timer           <= 8'd0;
      err_count       <= 4'd0;
      err_a           <= 1'b0;
      err_b           <= 1'b0;
      first_err_vec   <= 3'd0;
      first_err_valid <= 1'b0;
    end else if (launch) begin
      vec             <= 3'd0;
      timer           <= 8'd0;
      err_count       <= 4'd0;
      err_a           <= 1'b0;
      err_b           <= 1'b0;
      first_err_vec   <= 3'd0;
      first_err_valid <= 1'b0;
    end else if (state == APPLY) begin
      if (sample) begin
        if (mis_a || mis_b) begin
          if (err_count != 4'hf) err_count <= err_count + 4'd1;
          if (mis_a) err_a <= 1'b1;
          if (mis_b) err_b <= 1'b1;
          if (!first_err_valid) begin
            first_err_vec   <= vec;
            first_err_valid <= 1'b1;
          end
        end
        // On the last vector vec and timer stay put so DONE shows vec=7.
        if (vec != 3'd7) begin
          vec   <= vec + 3'd1;
          timer <= 8'd0;
        end
      end else begin
        timer <= timer + 8'd1;
      end
    end
  end

  assign bus.vec             = vec;
  assign bus.busy            = (state == APPLY);
  assign bus.done            = (state == DONE);
  assign bus.pass            = (state == DONE) && (err_count == 4'd0);
  assign bus.err_count       = err_count;
  assign bus.err_a           = err_a;
  assign bus.err_b           = err_b;
  assign bus.first_err_vec   = first_err_vec;
  assign bus.first_err_valid = first_err_valid;
  assign bus.fsm_state       = state;
endmodule

// File: tb/tb_popcount_bist_checker.sv
// Directed bench for popcount_bist_checker: one DWELL=4 instance with fault-injecting counter models
// and one DWELL=2 instance with good counters.
module tb_popcount_bist_checker;
  logic clk;
  logic rst;
  logic fault_a_stuck;
  logic fault_b_vec3;
  int   n_checks;
  int   n_fail;

  popcount_bist_checker_if bus ();
  popcount_bist_checker_if bus2 ();

  popcount_bist_checker #(.DWELL(4)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  popcount_bist_checker #(.DWELL(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [1:0] golden(input logic [2:0] v);
    case (v)
      3'd0:                 golden = 2'd0;
      3'd1, 3'd2, 3'd4:     golden = 2'd1;
      3'd3, 3'd5, 3'd6:     golden = 2'd2;
      default:              golden = 2'd3;
    endcase
  endfunction

  always_comb begin
    bus.dut_a  = fault_a_stuck ? 2'b00 : golden(bus.vec);
    bus.dut_b  = (fault_b_vec3 && bus.vec == 3'd3) ? 2'b01 : golden(bus.vec);
    bus2.dut_a = golden(bus2.vec);
    bus2.dut_b = golden(bus2.vec);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus2.start = 1'b0;
    fault_a_stuck = 1'b0;
    fault_b_vec3 = 1'b0;
    do_reset();
    n_checks++; if (bus.vec !== 3'd0) begin n_fail++; $display("FAIL reset_vec got %0d want 0", bus.vec); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_checks++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %b want 0", bus.pass); end
    n_checks++; if (bus.err_count !== 4'd0) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", bus.err_count); end
    n_checks++; if ({bus.err_a, bus.err_b, bus.first_err_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {bus.err_a, bus.err_b, bus.first_err_valid}); end
    n_checks++; if (bus.first_err_vec !== 3'd0) begin n_fail++; $display("FAIL reset_first_err_vec got %0d want 0", bus.first_err_vec); end
    n_checks++; if (bus.fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.fsm_state); end
  endtask

  task automatic test_good();
    do_reset();
    pulse_start();
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL good_busy_after_start got %b want 1", bus.busy); end
    n_checks++; if (bus.vec !== 3'd0) begin n_fail++; $display("FAIL good_vec0 got %0d want 0", bus.vec); end
    for (int n = 1; n < 8; n++) begin
      repeat (4) cyc();
      n_checks++; if (bus.vec !== 3'(n)) begin n_fail++; $display("FAIL good_vec_step got %0d want %0d", bus.vec, n); end
    end
    repeat (3) cyc();
    n_checks++; if ({bus.busy, bus.done} !== 2'b10) begin n_fail++; $display("FAIL good_cycle31 busy,done got %b want 10", {bus.busy, bus.done}); end
    cyc();
    n_checks++; if ({bus.busy, bus.done, bus.pass} !== 3'b011) begin n_fail++; $display("FAIL good_end busy,done,pass got %b want 011", {bus.busy, bus.done, bus.pass}); end
    n_checks++; if (bus.err_count !== 4'd0) begin n_fail++; $display("FAIL good_err_count got %0d want 0", bus.err_count); end
    n_checks++; if ({bus.err_a, bus.err_b, bus.first_err_valid} !== 3'b000) begin n_fail++; $display("FAIL good_flags got %b want 000", {bus.err_a, bus.err_b, bus.first_err_valid}); end
    n_checks++; if (bus.vec !== 3'd7) begin n_fail++; $display("FAIL good_vec_done got %0d want 7", bus.vec); end
    repeat (3) cyc();
    n_checks++; if ({bus.done, bus.pass, bus.vec} !== {2'b11, 3'd7}) begin n_fail++; $display("FAIL good_done_hold got %b want 11111", {bus.done, bus.pass, bus.vec}); end
  endtask

  task automatic test_single_fault();
    do_reset();
    fault_b_vec3 = 1'b1;
    pulse_start();
    repeat (32) cyc();
    n_checks++; if ({bus.done, bus.pass} !== 2'b10) begin n_fail++; $display("FAIL single_done_pass got %b want 10", {bus.done, bus.pass}); end
    n_checks++; if (bus.err_count !== 4'd1) begin n_fail++; $display("FAIL single_err_count got %0d want 1", bus.err_count); end
    n_checks++; if ({bus.err_a, bus.err_b} !== 2'b01) begin n_fail++; $display("FAIL single_err_ab got %b want 01", {bus.err_a, bus.err_b}); end
    n_checks++; if ({bus.first_err_valid, bus.first_err_vec} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL single_first_err got valid=%b vec=%0d want valid=1 vec=3", bus.first_err_valid, bus.first_err_vec); end
    fault_b_vec3 = 1'b0;
  endtask

  task automatic test_stuck();
    do_reset();
    fault_a_stuck = 1'b1;
    pulse_start();
    repeat (32) cyc();
    n_checks++; if ({bus.done, bus.pass} !== 2'b10) begin n_fail++; $display("FAIL stuck_done_pass got %b want 10", {bus.done, bus.pass}); end
    n_checks++; if (bus.err_count !== 4'd7) begin n_fail++; $display("FAIL stuck_err_count got %0d want 7", bus.err_count); end
    n_checks++; if ({bus.err_a, bus.err_b} !== 2'b10) begin n_fail++; $display("FAIL stuck_err_ab got %b want 10", {bus.err_a, bus.err_b}); end
    n_checks++; if ({bus.first_err_valid, bus.first_err_vec} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL stuck_first_err got valid=%b vec=%0d want valid=1 vec=1", bus.first_err_valid, bus.first_err_vec); end
    fault_a_stuck = 1'b0;
  endtask

  task automatic test_restart();
    do_reset();
    fault_a_stuck = 1'b1;
    pulse_start();
    repeat (9) cyc();
    pulse_start();
    n_checks++; if ({bus.busy, bus.vec} !== {1'b1, 3'd2}) begin n_fail++; $display("FAIL restart_ignored busy,vec got %b want 1010", {bus.busy, bus.vec}); end
    repeat (21) cyc();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL restart_cycle31_done got %b want 0", bus.done); end
    cyc();
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL restart_cycle32_done got %b want 1", bus.done); end
    n_checks++; if (bus.err_count !== 4'd7) begin n_fail++; $display("FAIL restart_err_count got %0d want 7", bus.err_count); end
    fault_a_stuck = 1'b0;
    pulse_start();
    n_checks++; if ({bus.done, bus.busy, bus.vec} !== {2'b01, 3'd0}) begin n_fail++; $display("FAIL restart_from_done done,busy,vec got %b want 01000", {bus.done, bus.busy, bus.vec}); end
    n_checks++; if ({bus.err_count, bus.err_a, bus.err_b, bus.first_err_valid, bus.first_err_vec} !== 10'd0) begin n_fail++; $display("FAIL restart_clear got cnt=%0d a=%b b=%b fv=%b fvec=%0d want all 0", bus.err_count, bus.err_a, bus.err_b, bus.first_err_valid, bus.first_err_vec); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    fault_a_stuck = 1'b1;
    pulse_start();
    repeat (12) cyc();
    n_checks++; if ({bus.vec, bus.err_count} !== {3'd3, 4'd2}) begin n_fail++; $display("FAIL midrst_before vec=%0d cnt=%0d want vec=3 cnt=2", bus.vec, bus.err_count); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++; if ({bus.vec, bus.busy, bus.done} !== 5'd0) begin n_fail++; $display("FAIL midrst_after vec=%0d busy=%b done=%b want 0 0 0", bus.vec, bus.busy, bus.done); end
    n_checks++; if ({bus.err_count, bus.err_a, bus.first_err_valid} !== 6'd0) begin n_fail++; $display("FAIL midrst_results cnt=%0d a=%b fv=%b want 0 0 0", bus.err_count, bus.err_a, bus.first_err_valid); end
    n_checks++; if (bus.fsm_state !== 2'd0) begin n_fail++; $display("FAIL midrst_state got %0d want 0", bus.fsm_state); end
    repeat (40) cyc();
    n_checks++; if ({bus.done, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL midrst_no_done done,busy got %b want 00", {bus.done, bus.busy}); end
    fault_a_stuck = 1'b0;
  endtask

  task automatic test_min_dwell();
    do_reset();
    bus2.start = 1'b1;
    cyc();
    bus2.start = 1'b0;
    repeat (2) cyc();
    n_checks++; if (bus2.vec !== 3'd1) begin n_fail++; $display("FAIL dwell2_vec1 got %0d want 1", bus2.vec); end
    repeat (13) cyc();
    n_checks++; if ({bus2.busy, bus2.done} !== 2'b10) begin n_fail++; $display("FAIL dwell2_cycle15 busy,done got %b want 10", {bus2.busy, bus2.done}); end
    cyc();
    n_checks++; if ({bus2.done, bus2.pass, bus2.err_count} !== {2'b11, 4'd0}) begin n_fail++; $display("FAIL dwell2_end done=%b pass=%b cnt=%0d want 1 1 0", bus2.done, bus2.pass, bus2.err_count); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    test_reset();
    test_good();
    test_single_fault();
    test_stuck();
    test_restart();
    test_reset_mid_run();
    test_min_dwell();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/popcount_bist_checker.md
# popcount_bist_checker

Self-test sequencer for the 3-input ones-counter (behavioural and gate-level versions). On `start` it drives all eight input vectors 0 to 7 onto the counters. It holds each vector for a fixed settle window, then compares both 2-bit results against a built-in golden population count and records mismatches. It is the synthesizable response-checking end of the counter interface and replaces hand-driven stimulus on the board or in simulation.

## Interface
Parameters:
- `DWELL`, default 4: cycles each vector is held, including the sample cycle. Legal range is 2..255.

Ports:
- `clk` input, 1: single clock. All state updates on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `start` input, 1: begin a run. Sampled only in IDLE or DONE.
- `vec` output, 3: `{a,b,c}` vector driven to both counters. `vec[2]` is `a`.
- `dut_a` input, 2: `{carry,sum}` result of the behavioural counter.
- `dut_b` input, 2: `{carry,sum}` result of the gate-level counter.
- `busy` output, 1: high while a run is in progress.
- `done` output, 1: high in DONE until the next start or reset.
- `pass` output, 1: valid when `done`=1. 1 when `err_count`==0.
- `err_count` output, 4: number of vectors on which either counter mismatched.
- `err_a`, `err_b` outputs, 1 each: sticky flags. Set when `dut_a` or `dut_b` respectively mismatched at least once this run.
- `first_err_vec` output, 3: vector of the first mismatch this run.
- `first_err_valid` output, 1: qualifies `first_err_vec`.

## Operation
- States: IDLE, APPLY, DONE.
- Reset values: state IDLE, `vec`=0, internal timer=0, all flags 0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_vec`=0.
- **IDLE**
  - `vec` holds 0.
  - On `start`=1: clear `err_count`, `err_a`, `err_b`, `first_err_valid` and `first_err_vec`; set `vec`=0 and timer=0; go to APPLY.
- **APPLY**
  - `busy`=1.
  - Timer increments each cycle while timer < DWELL-1.
  - Sample cycle is the cycle with timer==DWELL-1. In it:
    - `exp` = a+b+c, a 2-bit golden popcount.
    - `mis_a` = (`dut_a`!=`exp`); `mis_b` = (`dut_b`!=`exp`).
    - If `mis_a` or `mis_b`: increment `err_count` once, set the corresponding sticky flags, and if `first_err_valid`=0 capture `first_err_vec`=`vec` and set `first_err_valid`=1.
    - If `vec`==7, go to DONE. Otherwise `vec` increments by 1 and timer=0.
- **DONE**
  - `busy`=0, `done`=1.
  - `pass` = (`err_count`==0).
  - `vec` holds 7.
  - Result registers hold.
  - `start`=1 behaves as in IDLE (restart, clears results, `done` drops the next cycle).
- `start` during APPLY is ignored.
- `err_count` saturates at 15. In practice it never exceeds 8.
- `rst`=1 in any state, including mid-run, forces all reset values on the next edge. Partial results are discarded.
- `dut_a` and `dut_b` are compared combinationally in the sample cycle only. Values outside the sample cycle are don't-care.

## Timing
- Start accepted at edge k. `vec`=0 and `busy`=1 are visible after edge k.
- Vector n (n=0..7) is driven for cycles k+n·DWELL through k+(n+1)·DWELL-1.
- The sample for vector n is taken at edge k+(n+1)·DWELL.
- `done`=1, `busy`=0 and final `pass` are visible after edge k+8·DWELL. Total run is 8·DWELL cycles; 32 cycles at the default.
- The counters have DWELL-1 full cycles to settle after each `vec` change.
- `err_count` and the flags update at the sample edge and are visible the following cycle.

## Test plan
- **Good DUTs:** both inputs tied to popcount(`vec`), DWELL=4, pulse `start` → `vec` steps 0..7 every 4 cycles. After 32 cycles: `done`=1, `pass`=1, `err_count`=0, `err_a`=`err_b`=0, `first_err_valid`=0.
- **Single fault:** `dut_b` returns 2'b01 for vector 3 (expected 2'b10), `dut_a` correct → `err_count`=1, `err_b`=1, `err_a`=0, `first_err_vec`=3, `pass`=0.
- **Stuck output:** `dut_a` stuck at 2'b00, `dut_b` correct → `err_count`=7 (all vectors except 0), `err_a`=1, `first_err_vec`=1.
- **Restart and ignored start:** pulse `start` mid-run at cycle 10 → ignored, run still ends at cycle 32. Then `start` in DONE → all results clear and `done`=0 one cycle later.
- **Reset mid-run:** `rst` at cycle 13 (`vec`=3) with errors already logged → next cycle `vec`=0, `busy`=0, `err_count`=0, state IDLE. No `done` is produced.
- **Minimum dwell:** DWELL=2 with a good DUT → `done` after 16 cycles and `pass`=1.
